// File: rtl/arb_pkg.sv
// Shared types for the request/grant arbitration protocol.
// Used by the arbiter, the requester and the benches.
//   NUM_CLIENTS : number of arbitration clients
//   req_state_t : requester channel state
package arb_pkg;

    localparam int NUM_CLIENTS = 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        OWN,
        RELEASE
    } req_state_t;

endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: job queue counter, request FSM, wait/beat counters
// and single-cycle status pulses. All outputs are registered.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : enqueue one job (pulse per job)
//   grant        : arbiter grant for this client
//   request      : request to the arbiter
//   done         : burst completed pulse
//   timeout_err  : job abandoned pulse
//   ovf          : start dropped, queue full pulse
//   bad_grant    : grant seen while IDLE or RELEASE pulse
//   pending      : queued job count
module arb_req_chan
    import arb_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned PEND_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              grant,
    output logic              request,
    output logic              done,
    output logic              timeout_err,
    output logic              ovf,
    output logic              bad_grant,
    output logic [PEND_W-1:0] pending
);

    localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    req_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [PEND_W-1:0] pend_d;
    logic              request_d, done_d, tmo_d, ovf_d, bad_d;
    logic              job_end;

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            beat_q      <= '0;
            pending     <= '0;
            request     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            ovf         <= 1'b0;
            bad_grant   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            beat_q      <= beat_d;
            pending     <= pend_d;
            request     <= request_d;
            done        <= done_d;
            timeout_err <= tmo_d;
            ovf         <= ovf_d;
            bad_grant   <= bad_d;
        end
    end

    // Next-state, counters and pulse decode
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        ovf_d   = 1'b0;
        pend_d  = pending;

        unique case (state_q)
            IDLE: begin
                wait_d = '0;
                beat_d = '0;
                if (pending != '0 || start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (grant) begin
                    state_d = OWN;
                    wait_d  = '0;
                    beat_d  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = RELEASE;
                    tmo_d   = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            OWN: begin
                if (grant) begin
                    if (beat_q == BEAT_LAST) begin
                        state_d = RELEASE;
                        done_d  = 1'b1;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else begin
                    // Preempted: job stays queued, burst restarts from zero
                    state_d = REQ;
                    beat_d  = '0;
                    wait_d  = '0;
                end
            end
            RELEASE: begin
                // One low cycle; with more work queued, pass through IDLE
                // without spending a cycle there so the gap stays at one.
                wait_d = '0;
                beat_d = '0;
                if (pending != '0 || start) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pending queue: simultaneous enqueue and consume cancel out
        job_end = done_d | tmo_d;
        if (start && !job_end) begin
            if (pending == {PEND_W{1'b1}}) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pending + PEND_W'(1);
            end
        end else if (!start && job_end && pending != '0) begin
            pend_d = pending - PEND_W'(1);
        end

        request_d = (state_d == REQ) || (state_d == OWN);
        bad_d     = grant && ((state_q == IDLE) || (state_q == RELEASE));
    end

endmodule

// File: rtl/arb_requester.sv
// Requester side of the two-client request/grant protocol: one independent
// arb_req_chan per client, bit i of every vector belongs to client i.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : per-client job enqueue pulse
//   grant        : arbiter grant
//   request      : per-client request
//   done         : per-client burst-completed pulse
//   timeout_err  : per-client job-abandoned pulse
//   ovf          : per-client queue-full drop pulse
//   bad_grant    : per-client unexpected grant pulse
//   pending0/1   : queued job count for client 0/1
module arb_requester
    import arb_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned PEND_W    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] start,
    input  logic [NUM_CLIENTS-1:0] grant,
    output logic [NUM_CLIENTS-1:0] request,
    output logic [NUM_CLIENTS-1:0] done,
    output logic [NUM_CLIENTS-1:0] timeout_err,
    output logic [NUM_CLIENTS-1:0] ovf,
    output logic [NUM_CLIENTS-1:0] bad_grant,
    output logic [PEND_W-1:0]      pending0,
    output logic [PEND_W-1:0]      pending1
);

    logic [PEND_W-1:0] pend [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_chan
        arb_req_chan #(
            .BURST_LEN (BURST_LEN),
            .TIMEOUT   (TIMEOUT),
            .PEND_W    (PEND_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .start       (start[i]),
            .grant       (grant[i]),
            .request     (request[i]),
            .done        (done[i]),
            .timeout_err (timeout_err[i]),
            .ovf         (ovf[i]),
            .bad_grant   (bad_grant[i]),
            .pending     (pend[i])
        );
    end

    assign pending0 = pend[0];
    assign pending1 = pend[1];

endmodule

// File: doc/arb_requester.md
# arb_requester

Requester side of the two-client `request`/`grant` arbitration protocol. It queues jobs per client and raises `request[i]` while a job is pending. It holds `request[i]` through a fixed-length ownership burst once `grant[i]` arrives, then releases it. It sits opposite the arbiter on `arb_if` and replaces hand-driven `request` stimulus in tests and in the integrated design.

## Interface
Parameters:
- `BURST_LEN`, default 4: cycles of ownership per job, ≥1.
- `TIMEOUT`, default 16: cycles in REQ without grant before the job is abandoned, ≥2.
- `PEND_W`, default 3: pending-job counter width; max `2**PEND_W-1` queued jobs per client.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  2  per-client job enqueue pulse, one job per cycle high.
- `grant`  in  2  arbiter grant, sampled on `posedge clk`.
- `request`  out  2  per-client request, registered.
- `done`  out  2  one-cycle pulse, job burst completed.
- `timeout_err`  out  2  one-cycle pulse, job abandoned after TIMEOUT.
- `ovf`  out  2  one-cycle pulse, `start` dropped because queue full.
- `bad_grant`  out  2  one-cycle pulse, `grant[i]` high while client i in IDLE or RELEASE.
- `pending0`, `pending1`  out  PEND_W  queued job count per client.

## Operation
- Two identical independent channels. Channel i uses only `start[i]`/`grant[i]` and drives only bit i of each output.
- Per-channel FSM:
  - **IDLE**: `request`=0. Go to REQ when `pending!=0 || start`.
  - **REQ**: `request`=1, `wait_cnt` increments each cycle.
    - `grant`=1 → OWN, `beat_cnt`=0, `wait_cnt`=0.
    - Else if `wait_cnt==TIMEOUT-1` → RELEASE, `timeout_err` pulse, pending−1.
  - **OWN**: `request`=1.
    - `grant`=1 and `beat_cnt==BURST_LEN-1` → RELEASE, `done` pulse, pending−1.
    - `grant`=1 otherwise → `beat_cnt`+1.
    - `grant`=0 (preemption) → REQ, `beat_cnt`=0, `wait_cnt`=0. The job is not consumed and the burst restarts from zero.
  - **RELEASE**: `request`=0 for exactly one cycle, then IDLE.
- Pending counter:
  - `start` adds 1, completion or timeout subtracts 1.
  - Both in the same cycle: unchanged.
  - `start` when `pending==2**PEND_W-1` and no decrement that cycle: ignored, `ovf` pulse.
- `bad_grant` fires for any sampled `grant[i]`=1 in IDLE or RELEASE. State is unaffected.
- Reset values: every output is 0, including `request`=2'b00, matching the arbiter's reset grant of 2'b00. All channels go to IDLE and all counters clear.
- `rst` mid-burst aborts immediately with no `done` or `timeout_err`, and queued jobs are discarded.

## Timing
- `start` high at edge k with channel IDLE → `request` high after edge k (1-cycle latency).
- Grant sampled at edge m in REQ → OWN. The burst ends at edge m+BURST_LEN if `grant` is held.
  - `request` falls and `done` is high after that edge.
  - `done` lasts exactly one cycle.
- Minimum gap between consecutive jobs of one client: 1 low cycle of `request` (RELEASE). The next `request` rise comes one cycle later.
- Timeout: `request` is high for exactly TIMEOUT cycles, then `timeout_err` and `request`=0 take effect on the same edge.
- All outputs are registered. There is no combinational path from `grant` or `start` to any output.

## Structure
- Package `arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, REQ, OWN, RELEASE} req_state_t`.
  - `localparam int NUM_CLIENTS = 2`.
  - Shared by the arbiter, the requester and the benches.
- Sub-module `arb_req_chan`: one channel (FSM, pending, wait and beat counters, pulse outputs). It is instantiated twice by `arb_requester`.
- `arb_requester` carries a modport-compatible port list so it connects directly to `arb_if` fields.

## Test plan
With BURST_LEN=4, TIMEOUT=16, PEND_W=3:
- **Reset:** assert `rst` mid-OWN → `request`=00, all pulses 0, `pending0`=`pending1`=0 immediately (asynchronous).
- **Single job:** `start`=01 one cycle; grant `01` two cycles later and held → `request[0]` high 1+2+4 cycles, `done[0]` single pulse, `pending0` 1→0.
- **Timeout:** `start`=10, `grant` held 00 → `request[1]` high 16 cycles, then `timeout_err[1]` pulse, `request`=00, `pending1`=0.
- **Preemption:** `grant[0]` high 2 cycles, low 1 cycle, high again → burst restarts; `done[0]` only after 4 further consecutive grant cycles.
- **Queue full:** 8 `start[0]` pulses with no grant → `pending0`=7, `ovf[0]` on the 8th. Then grant continuously → 7 `done[0]` pulses separated by 1-cycle `request` gaps.
- **Contention / bad grant:** both clients started, arbiter alternates grants → channels independent, `done`=01 and 10 at distinct cycles. `grant`=01 while client 0 IDLE → `bad_grant[0]` one pulse, no state change.
